// File: rtl/settings_bus_arbiter_pkg.sv
// Shared definitions for the settings-bank round-robin arbiter:
// FSM state encodings, logic level constants and the default protected base address.
package settings_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic HIGH = 1'b1;
   localparam logic LOW  = 1'b0;
   localparam logic DRST = 1'b0;   // asserted level of rstb

   localparam logic [7:0] PROT_BASE_DEFAULT = 8'hF0;

endpackage

// File: rtl/settings_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after the last grant,
// searching cyclically, plus a flag telling whether any requester is valid.
module rr_arbiter
   import settings_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IDXW    = 2
) (
   input  logic [NUM_REQ-1:0] i_req_valid,
   input  logic [IDXW-1:0]    i_last_grant,
   output logic [IDXW-1:0]    o_grant,
   output logic               o_found
);

   localparam int W = IDXW + 1;

   logic [W-1:0] w_idx;

   // Walk offsets from farthest to nearest so the nearest valid requester wins.
   always_comb begin
      o_grant = '0;
      o_found = LOW;
      w_idx   = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         w_idx = {1'b0, i_last_grant} + W'(i);
         if (w_idx >= W'(NUM_REQ))
            w_idx = w_idx - W'(NUM_REQ);
         if (i_req_valid[w_idx[IDXW-1:0]] == HIGH) begin
            o_grant = w_idx[IDXW-1:0];
            o_found = HIGH;
         end
      end
   end

endmodule

// File: rtl/settings_bus_arbiter.sv
// Round-robin arbiter serialising read/write transactions from NUM_REQ requesters onto
// the single-port settings bank. Define SETTINGS_ARB_WRPROT_EN to write-protect addr >= PROT_BASE.
//
// state | meaning
// IDLE  | arbitrate among valid requests, latch the winner
// ISSUE | ready to winner, address/data (and write strobe) on the bank
// WAIT  | count down the bank read latency, capture read data
// RESP  | response strobe to winner, remember it as last grant
module settings_bus_arbiter
   import settings_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ             = 3,
   parameter int SETTINGS_ADDR_WIDTH = 8,
   parameter int SETTINGS_DATA_WIDTH = 16,
   parameter int READ_LATENCY        = 1,
   parameter logic [SETTINGS_ADDR_WIDTH-1:0] PROT_BASE = SETTINGS_ADDR_WIDTH'(PROT_BASE_DEFAULT)
) (
   input  logic                                   clk,
   input  logic                                   rstb,
   input  logic [NUM_REQ-1:0]                     req_valid,
   input  logic [NUM_REQ-1:0]                     req_write,
   input  logic [NUM_REQ*SETTINGS_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*SETTINGS_DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]                     req_ready,
   output logic [NUM_REQ-1:0]                     rsp_valid,
   output logic [NUM_REQ-1:0]                     rsp_err,
   output logic [SETTINGS_DATA_WIDTH-1:0]         rsp_rdata,
   output logic [SETTINGS_ADDR_WIDTH-1:0]         settings_addr,
   output logic [SETTINGS_DATA_WIDTH-1:0]         settings_data_in,
   output logic                                   settings_write_en,
   input  logic [SETTINGS_DATA_WIDTH-1:0]         settings_data_out
);

   localparam int IDXW = $clog2(NUM_REQ);
   localparam int CNTW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(READ_LATENCY - 1);

   state_t r_state;
   state_t w_state_nxt;

   logic [IDXW-1:0] r_grant;
   logic [IDXW-1:0] r_last_grant;
   logic            r_write;
   logic            r_prot;
   logic [CNTW-1:0] r_cnt;

   logic [NUM_REQ-1:0]             r_req_ready;
   logic [NUM_REQ-1:0]             r_rsp_valid;
   logic [NUM_REQ-1:0]             r_rsp_err;
   logic [SETTINGS_DATA_WIDTH-1:0] r_rsp_rdata;
   logic [SETTINGS_ADDR_WIDTH-1:0] r_settings_addr;
   logic [SETTINGS_DATA_WIDTH-1:0] r_settings_data_in;
   logic                           r_settings_write_en;

   logic [IDXW-1:0]                w_grant;
   logic                           w_found;
   logic                           w_sel_write;
   logic [SETTINGS_ADDR_WIDTH-1:0] w_sel_addr;
   logic [SETTINGS_DATA_WIDTH-1:0] w_sel_wdata;
   logic                           w_prot_hit;

   logic                           w_load;
   logic                           w_capture;
   logic                           w_cnt_load;
   logic                           w_cnt_dec;
   logic                           w_rsp_done;
   logic [NUM_REQ-1:0]             w_req_ready_nxt;
   logic [NUM_REQ-1:0]             w_rsp_valid_nxt;
   logic [NUM_REQ-1:0]             w_rsp_err_nxt;
   logic                           w_write_en_nxt;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDXW    (IDXW)
   ) u_rr_arbiter (
      .i_req_valid  (req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_found      (w_found)
   );

   assign w_sel_write = req_write[w_grant];
   assign w_sel_addr  = req_addr[w_grant*SETTINGS_ADDR_WIDTH +: SETTINGS_ADDR_WIDTH];
   assign w_sel_wdata = req_wdata[w_grant*SETTINGS_DATA_WIDTH +: SETTINGS_DATA_WIDTH];

`ifdef SETTINGS_ARB_WRPROT_EN
   // Requester 0 (UART) is the trusted path and may write the protected range.
   assign w_prot_hit = w_sel_write && (w_grant != '0) && (w_sel_addr >= PROT_BASE);
   assign rsp_err    = r_rsp_err;
`else
   logic w_unused_prot;
   assign w_prot_hit    = LOW;
   assign rsp_err       = '0;
   assign w_unused_prot = ^{PROT_BASE, r_rsp_err};
`endif

   always_ff @(posedge clk or negedge rstb) begin
      if (rstb == DRST)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = ST_IDLE;
      case (r_state)
         ST_IDLE:  w_state_nxt = w_found ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: w_state_nxt = r_write ? ST_RESP : ST_WAIT;
         ST_WAIT:  w_state_nxt = (r_cnt == '0) ? ST_RESP : ST_WAIT;
         ST_RESP:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are computed one state early so their registered copies line up with the state.
   always_comb begin
      w_load          = LOW;
      w_capture       = LOW;
      w_cnt_load      = LOW;
      w_cnt_dec       = LOW;
      w_rsp_done      = LOW;
      w_req_ready_nxt = '0;
      w_rsp_valid_nxt = '0;
      w_rsp_err_nxt   = '0;
      w_write_en_nxt  = LOW;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_load                   = HIGH;
               w_req_ready_nxt[w_grant] = HIGH;
               w_write_en_nxt           = w_sel_write & ~w_prot_hit;
            end
         end
         ST_ISSUE: begin
            if (r_write) begin
               w_rsp_valid_nxt[r_grant] = HIGH;
               w_rsp_err_nxt[r_grant]   = r_prot;
            end else begin
               w_cnt_load = HIGH;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_capture                = HIGH;
               w_rsp_valid_nxt[r_grant] = HIGH;
            end else begin
               w_cnt_dec = HIGH;
            end
         end
         ST_RESP: w_rsp_done = HIGH;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (rstb == DRST) begin
         r_grant             <= '0;
         r_last_grant        <= IDXW'(NUM_REQ - 1);
         r_write             <= LOW;
         r_prot              <= LOW;
         r_cnt               <= '0;
         r_req_ready         <= '0;
         r_rsp_valid         <= '0;
         r_rsp_err           <= '0;
         r_rsp_rdata         <= '0;
         r_settings_addr     <= '0;
         r_settings_data_in  <= '0;
         r_settings_write_en <= LOW;
      end else begin
         r_req_ready         <= w_req_ready_nxt;
         r_rsp_valid         <= w_rsp_valid_nxt;
         r_rsp_err           <= w_rsp_err_nxt;
         r_settings_write_en <= w_write_en_nxt;
         if (w_load) begin
            r_grant         <= w_grant;
            r_write         <= w_sel_write;
            r_prot          <= w_prot_hit;
            r_settings_addr <= w_sel_addr;
            if (w_sel_write)
               r_settings_data_in <= w_sel_wdata;
         end
         if (w_cnt_load)
            r_cnt <= CNT_LOAD;
         else if (w_cnt_dec)
            r_cnt <= r_cnt - 1'b1;
         if (w_capture)
            r_rsp_rdata <= settings_data_out;
         if (w_rsp_done)
            r_last_grant <= r_grant;
      end
   end

   assign req_ready         = r_req_ready;
   assign rsp_valid         = r_rsp_valid;
   assign rsp_rdata         = r_rsp_rdata;
   assign settings_addr     = r_settings_addr;
   assign settings_data_in  = r_settings_data_in;
   assign settings_write_en = r_settings_write_en;

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Testbench for settings_bus_arbiter: one instance with READ_LATENCY=1, one with READ_LATENCY=3,
// each backed by a bank model. Expectations follow SETTINGS_ARB_WRPROT_EN when it is defined.
`timescale 1ns/1ps
module tb_settings_bus_arbiter;

   localparam int N  = 3;
   localparam int AW = 8;
   localparam int DW = 16;

`ifdef SETTINGS_ARB_WRPROT_EN
   localparam logic PROT = 1'b1;
`else
   localparam logic PROT = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;

   // instance with READ_LATENCY = 1
   logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid, rsp_err;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, sd_in, sd_out;
   logic [AW-1:0]   s_addr;
   logic            s_we;

   // instance with READ_LATENCY = 3
   logic [N-1:0]    req_valid3, req_write3, req_ready3, rsp_valid3, rsp_err3;
   logic [N*AW-1:0] req_addr3;
   logic [N*DW-1:0] req_wdata3;
   logic [DW-1:0]   rsp_rdata3, sd_in3, sd_out3;
   logic [AW-1:0]   s_addr3;
   logic            s_we3;

   settings_bus_arbiter #(
      .NUM_REQ(N), .SETTINGS_ADDR_WIDTH(AW), .SETTINGS_DATA_WIDTH(DW), .READ_LATENCY(1)
   ) u_dut (
      .clk(clk), .rstb(rstb),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .settings_addr(s_addr), .settings_data_in(sd_in), .settings_write_en(s_we),
      .settings_data_out(sd_out)
   );

   settings_bus_arbiter #(
      .NUM_REQ(N), .SETTINGS_ADDR_WIDTH(AW), .SETTINGS_DATA_WIDTH(DW), .READ_LATENCY(3)
   ) u_dut3 (
      .clk(clk), .rstb(rstb),
      .req_valid(req_valid3), .req_write(req_write3), .req_addr(req_addr3), .req_wdata(req_wdata3),
      .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_err(rsp_err3), .rsp_rdata(rsp_rdata3),
      .settings_addr(s_addr3), .settings_data_in(sd_in3), .settings_write_en(s_we3),
      .settings_data_out(sd_out3)
   );

   // Bank models: contents start as {8'hA5, addr}.
   logic [DW-1:0] mem1 [256];
   logic [DW-1:0] mem3 [256];
   logic [DW-1:0] p3_0, p3_1;
   logic          mem_init = 1'b0;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int a = 0; a < 256; a++) begin
            mem1[a] = {8'hA5, 8'(a)};
            mem3[a] = {8'hA5, 8'(a)};
         end
         mem_init = 1'b1;
      end
      sd_out <= mem1[s_addr];
      p3_0   <= mem3[s_addr3];
      p3_1   <= p3_0;
      sd_out3 <= p3_1;
      if (s_we)  mem1[s_addr]  = sd_in;
      if (s_we3) mem3[s_addr3] = sd_in3;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int          req;
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic        exp_we;
      logic        exp_err;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs[14];

   // One isolated transaction on the latency-1 instance, checked cycle by cycle.
   task automatic run_txn(input vec_t v, input int k);
      logic [2:0] oh;
      oh = 3'b001 << v.req;
      req_valid = '0;
      req_write = '0;
      req_valid[v.req] = 1'b1;
      req_write[v.req] = v.wr;
      req_addr[v.req*AW +: AW]  = v.addr;
      req_wdata[v.req*DW +: DW] = v.wdata;
      tick();
      check($sformatf("v%0d ready", k), 32'(req_ready), 32'(oh));
      check($sformatf("v%0d addr", k), 32'(s_addr), 32'(v.addr));
      check($sformatf("v%0d we", k), 32'(s_we), 32'(v.exp_we));
      if (v.wr) check($sformatf("v%0d din", k), 32'(sd_in), 32'(v.wdata));
      tick();
      req_valid = '0;
      check($sformatf("v%0d we pulse", k), 32'(s_we), 32'd0);
      if (!v.wr) begin
         check($sformatf("v%0d rsp early", k), 32'(rsp_valid), 32'd0);
         tick();
      end
      check($sformatf("v%0d rsp_valid", k), 32'(rsp_valid), 32'(oh));
      check($sformatf("v%0d rsp_err", k), 32'(rsp_err), v.exp_err ? 32'(oh) : 32'd0);
      if (!v.wr) check($sformatf("v%0d rdata", k), 32'(rsp_rdata), 32'(v.exp_rdata));
      tick();
      check($sformatf("v%0d rsp pulse", k), 32'(rsp_valid), 32'd0);
   endtask

   int grants[4];
   int rr_exp[4];
   int ng, nr, last_g, gi;

   initial begin
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      req_valid3 = '0; req_write3 = '0; req_addr3 = '0; req_wdata3 = '0;

      vecs[0]  = '{1, 1'b1, 8'h10, 16'hBEEF, 1'b1,  1'b0, 16'h0000};
      vecs[1]  = '{0, 1'b0, 8'h10, 16'h0000, 1'b0,  1'b0, 16'hBEEF};
      vecs[2]  = '{2, 1'b0, 8'h20, 16'h0000, 1'b0,  1'b0, 16'hA520};
      vecs[3]  = '{0, 1'b1, 8'hFF, 16'h1357, 1'b1,  1'b0, 16'h0000};
      vecs[4]  = '{1, 1'b1, 8'hEF, 16'h2468, 1'b1,  1'b0, 16'h0000};
      vecs[5]  = '{2, 1'b1, 8'hF4, 16'h1234, !PROT, PROT, 16'h0000};
      vecs[6]  = '{2, 1'b0, 8'hF4, 16'h0000, 1'b0,  1'b0, PROT ? 16'hA5F4 : 16'h1234};
      vecs[7]  = '{0, 1'b1, 8'hF4, 16'h1234, 1'b1,  1'b0, 16'h0000};
      vecs[8]  = '{1, 1'b0, 8'hF4, 16'h0000, 1'b0,  1'b0, 16'h1234};
      vecs[9]  = '{1, 1'b1, 8'hF0, 16'h5555, !PROT, PROT, 16'h0000};
      vecs[10] = '{1, 1'b0, 8'hF0, 16'h0000, 1'b0,  1'b0, PROT ? 16'hA5F0 : 16'h5555};
      vecs[11] = '{2, 1'b0, 8'hFF, 16'h0000, 1'b0,  1'b0, 16'h1357};
      vecs[12] = '{0, 1'b0, 8'h00, 16'h0000, 1'b0,  1'b0, 16'hA500};
      vecs[13] = '{2, 1'b0, 8'hEF, 16'h0000, 1'b0,  1'b0, 16'h2468};
      rr_exp = '{0, 1, 2, 0};

      // reset values
      tick(); tick();
      check("rst ready", 32'(req_ready), 32'd0);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst we", 32'(s_we), 32'd0);
      rstb = 1'b1;
      tick();
      check("post-rst addr", 32'(s_addr), 32'd0);
      check("post-rst din", 32'(sd_in), 32'd0);
      check("post-rst rdata", 32'(rsp_rdata), 32'd0);
      check("post-rst err", 32'(rsp_err), 32'd0);
      check("post-rst ready", 32'(req_ready), 32'd0);

      // all three requesters continuously valid: grants rotate 0,1,2,0
      req_addr = {8'h03, 8'h02, 8'h01};
      req_write = '0;
      req_valid = 3'b111;
      ng = 0; nr = 0; last_g = 0;
      grants = '{-1, -1, -1, -1};
      for (int c = 0; c < 60 && nr < 4; c++) begin
         tick();
         if (req_ready != '0) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
            if (ng < 4) grants[ng] = gi;
            ng++;
            last_g = gi;
            if (ng == 4) req_valid = '0;
         end
         if (rsp_valid != '0) begin
            check($sformatf("rr rsp owner %0d", nr), 32'(rsp_valid), 32'(3'b001 << last_g));
            check($sformatf("rr rdata %0d", nr), 32'(rsp_rdata), 32'({8'hA5, 8'(last_g + 1)}));
            nr++;
         end
      end
      req_valid = '0;
      check("rr responses", 32'(nr), 32'd4);
      for (int k = 0; k < 4; k++) check($sformatf("rr grant %0d", k), 32'(grants[k]), 32'(rr_exp[k]));
      tick();

      // table of isolated transactions
      for (int k = 0; k < 14; k++) run_txn(vecs[k], k);

      // requester 1 drops while requester 2 raises during a busy write; last grant is 0
      req_valid = 3'b001; req_write = 3'b001;
      req_addr[7:0] = 8'h30; req_wdata[15:0] = 16'h0C0C;
      tick();
      check("skip r0 ready", 32'(req_ready), 32'h1);
      req_valid = 3'b011; req_addr[15:8] = 8'h40;
      tick();
      check("skip r0 rsp", 32'(rsp_valid), 32'h1);
      check("skip ready c2", 32'(req_ready), 32'h0);
      req_valid = 3'b100; req_write = 3'b000; req_addr[23:16] = 8'h50;
      tick();
      check("skip ready c3", 32'(req_ready), 32'h0);
      tick();
      check("skip r2 ready", 32'(req_ready), 32'h4);
      check("skip r2 addr", 32'(s_addr), 32'h50);
      tick();
      req_valid = '0;
      check("skip rsp early", 32'(rsp_valid), 32'h0);
      tick();
      check("skip r2 rsp", 32'(rsp_valid), 32'h4);
      check("skip r2 rdata", 32'(rsp_rdata), 32'hA550);
      tick();

      // READ_LATENCY = 3: response in cycle 5
      req_valid3 = 3'b001; req_write3 = '0; req_addr3[7:0] = 8'h07;
      tick();
      check("l3 ready", 32'(req_ready3), 32'h1);
      check("l3 addr", 32'(s_addr3), 32'h07);
      tick();
      req_valid3 = '0;
      for (int c = 2; c <= 4; c++) begin
         check($sformatf("l3 no rsp c%0d", c), 32'(rsp_valid3), 32'h0);
         tick();
      end
      check("l3 rsp", 32'(rsp_valid3), 32'h1);
      check("l3 rdata", 32'(rsp_rdata3), 32'hA507);
      tick();

      // reset asserted during WAIT of a read on the latency-3 instance
      req_valid3 = 3'b010; req_addr3[15:8] = 8'h08;
      tick();
      check("rw ready", 32'(req_ready3), 32'h2);
      tick();
      req_valid3 = '0;
      #2 rstb = 1'b0;
      #1;
      check("rw rst ready", 32'(req_ready3), 32'h0);
      check("rw rst rsp", 32'(rsp_valid3), 32'h0);
      check("rw rst rdata", 32'(rsp_rdata3), 32'h0);
      check("rw rst addr", 32'(s_addr3), 32'h0);
      check("rw rst we", 32'(s_we3), 32'h0);
      check("rw rst dut1 addr", 32'(s_addr), 32'h0);
      tick();
      rstb = 1'b1;
      for (int c = 0; c < 6; c++) begin
         check($sformatf("rw no rsp %0d", c), 32'(rsp_valid3), 32'h0);
         tick();
      end
      req_valid3 = 3'b101; req_write3 = '0;
      req_addr3[7:0] = 8'h09; req_addr3[23:16] = 8'h0A;
      tick();
      check("rw first grant", 32'(req_ready3), 32'h1);
      tick();
      req_valid3 = '0;
      tick(); tick(); tick();
      check("rw r0 rsp", 32'(rsp_valid3), 32'h1);
      check("rw r0 rdata", 32'(rsp_rdata3), 32'hA509);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
